// File: rtl/input_buffer_sub.sv
// Per-port input FIFO ahead of route computation: first-word-fall-through head,
// valid/ready on both sides, occupancy exported as congestion pressure.
module input_buffer_sub #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int AF_LEVEL = 6
) (
    input  logic                ib_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                rc_ready,
    output logic [WIDTH:0]      pressure_out,
    output logic                almost_full
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. ready_out depends only on occupancy, valid_out only on
    // occupancy, so neither side sees a combinational path from the other.

    localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] AF_C    = (WIDTH+1)'(AF_LEVEL);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH:0]      count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign ready_out = !full;
    assign valid_out = !empty;
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & rc_ready;

    assign data_out     = empty ? '0 : mem[rd_ptr];
    assign pressure_out = count;
    assign almost_full  = (count >= AF_C);

    always_ff @(posedge ib_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer_sub.sv
// Bench for input_buffer_sub: directed scenarios plus random traffic, checked
// against a queue model of FIFO occupancy and order.
module tb_input_buffer_sub;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 3;
    localparam int DATASIZE = 40;
    localparam int AF_LEVEL = 6;

    logic                ib_clk;
    logic                rst;
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                ready_out;
    logic [DATASIZE-1:0] data_out;
    logic                valid_out;
    logic                rc_ready;
    logic [WIDTH:0]      pressure_out;
    logic                almost_full;

    input_buffer_sub #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .ib_clk(ib_clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .rc_ready(rc_ready),
        .pressure_out(pressure_out),
        .almost_full(almost_full)
    );

    // Clock / reset block
    initial ib_clk = 1'b0;
    always #5 ib_clk = ~ib_clk;

    // Scoreboard state
    logic [DATASIZE-1:0] exp_q[$];
    logic [DATASIZE-1:0] out_log[$];
    int checks = 0;
    int errors = 0;
    logic accepted;

    task automatic chk(input string tag, input logic [DATASIZE-1:0] obs,
                       input logic [DATASIZE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATASIZE-1:0] exp_head;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk({tag, ".valid_out"}, 40'(valid_out), 40'(exp_q.size() > 0));
        chk({tag, ".data_out"}, data_out, exp_head);
        chk({tag, ".ready_out"}, 40'(ready_out), 40'(exp_q.size() < DEPTH));
        chk({tag, ".pressure"}, 40'(pressure_out), 40'(exp_q.size()));
        chk({tag, ".almost_full"}, 40'(almost_full), 40'(exp_q.size() >= AF_LEVEL));
    endtask

    // Driver: apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic v, input logic [DATASIZE-1:0] d,
                        input logic r, input logic rs, input string tag);
        logic do_push;
        logic do_pop;
        valid_in = v;
        data_in  = d;
        rc_ready = r;
        rst      = rs;
        do_push  = !rs && v && (exp_q.size() < DEPTH);
        do_pop   = !rs && r && (exp_q.size() > 0);
        if (do_pop) out_log.push_back(data_out);
        @(posedge ib_clk);
        if (rs) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
        end
        accepted = do_push;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DATASIZE-1:0] nxt;
        logic [DATASIZE-1:0] rnd;
        logic [DATASIZE-1:0] flit;
        flit     = 40'h0_2_55_AAAAA_1;
        rst      = 1'b1;
        valid_in = 1'b0;
        rc_ready = 1'b0;
        data_in  = '0;

        // Reset then idle
        step(1'b0, '0, 1'b0, 1'b1, "rst0");
        step(1'b0, '0, 1'b0, 1'b1, "rst1");
        step(1'b0, '0, 1'b0, 1'b0, "idle");
        chk("reset.ready_out", 40'(ready_out), 40'd1);
        chk("reset.valid_out", 40'(valid_out), 40'd0);
        chk("reset.data_out", data_out, 40'd0);
        chk("reset.pressure", 40'(pressure_out), 40'd0);
        chk("reset.almost_full", 40'(almost_full), 40'd0);

        // Single flit: one-cycle latency, then pop
        step(1'b1, flit, 1'b0, 1'b0, "single_push");
        chk("single.data_out", data_out, flit);
        chk("single.pressure", 40'(pressure_out), 40'd1);
        step(1'b0, '0, 1'b1, 1'b0, "single_pop");
        chk("single_pop.valid_out", 40'(valid_out), 40'd0);

        // Fill to full with 1..8; almost_full rises after the 6th push
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 40'(i), 1'b0, 1'b0, "fill");
            chk("fill.almost_full", 40'(almost_full), 40'(i >= AF_LEVEL));
        end
        chk("full.ready_out", 40'(ready_out), 40'd0);
        chk("full.pressure", 40'(pressure_out), 40'd8);
        step(1'b1, 40'd99, 1'b0, 1'b0, "full_hold");
        chk("full_hold.rejected", 40'(accepted), 40'd0);

        // Drain across the pointer wrap while pushing 9..12 as space frees
        out_log.delete();
        nxt = 40'd9;
        for (int c = 0; c < 30; c++) begin
            if (nxt <= 40'd12) begin
                step(1'b1, nxt, 1'b1, 1'b0, "drain");
                if (accepted) nxt++;
            end else begin
                step(1'b0, '0, 1'b1, 1'b0, "drain");
            end
            chk("drain.pressure_max", 40'(pressure_out <= 4'(DEPTH)), 40'd1);
        end
        chk("drain.count", 40'(out_log.size()), 40'd12);
        for (int i = 0; i < out_log.size() && i < 12; i++) begin
            chk("drain.order", out_log[i], 40'(i + 1));
        end
        chk("drain.empty", 40'(valid_out), 40'd0);

        // Streaming with a 1-flit prefill
        step(1'b1, 40'h100, 1'b0, 1'b0, "prefill");
        for (int c = 1; c <= 20; c++) begin
            step(1'b1, 40'(40'h100 + c), 1'b1, 1'b0, "stream");
            chk("stream.pressure", 40'(pressure_out), 40'd1);
            chk("stream.head", data_out, 40'(40'h100 + c));
        end
        step(1'b0, '0, 1'b1, 1'b0, "stream_end");

        // Reset mid-operation with 5 stored flits and an active handshake
        for (int i = 0; i < 5; i++) step(1'b1, 40'(40'h200 + i), 1'b0, 1'b0, "pre_rst");
        step(1'b1, 40'h2FF, 1'b1, 1'b1, "mid_rst");
        chk("mid_rst.pressure", 40'(pressure_out), 40'd0);
        chk("mid_rst.valid_out", 40'(valid_out), 40'd0);
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, 1'b0, "post_rst");

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            rnd = {8'($urandom), 32'($urandom)};
            step(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 79) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
